// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default parameter
// values, the arbiter state encoding and a counter-width helper.
package mem_arb_pkg;

  localparam int AW_DEF         = 16;
  localparam int DW_DEF         = 16;
  localparam int MAX_DM_RUN_DEF = 3;
  localparam int TIMEOUT_DEF    = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERV_IF = 3'd1,
    ST_SERV_DM = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_ERR     = 3'd4
  } arb_state_e;

  // Bits needed to hold a count from 0 up to and including max_val.
  function automatic int cnt_w(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/arb_timeout.sv
// Access watchdog: restarts on load, counts enabled cycles and flags expire
// on the TIMEOUT-th enabled cycle after load.
module arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on load, advance while enabled, saturate at the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable & (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between a read-only
// fetch port and a read/write data port, one access at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MAX_DM_RUN = MAX_DM_RUN_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_cancel,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          err
);

  localparam int            RW      = cnt_w(MAX_DM_RUN);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DM_RUN);

  arb_state_e    state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wr_q, mem_wr_d;
  logic          acc_wr_q, acc_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          dm_valid_q, dm_valid_d;
  logic          err_q, err_d;

  logic if_elig, dm_elig, fetch_turn, dm_next;
  logic gnt_if, gnt_dm;
  logic to_load, to_en, to_expire;

  assign if_elig    = if_req & ~if_valid_q;
  assign dm_elig    = dm_req & ~dm_valid_q;
  assign fetch_turn = (run_q >= RUN_MAX);
  // A data request still high during its valid pulse is the next back-to-back
  // access; fetch only takes that slot once the data run limit is reached.
  assign dm_next    = dm_req & dm_valid_q & ~fetch_turn;

  // Grant selection in IDLE: data wins unless fetch has waited out the run limit.
  always_comb begin
    gnt_if = 1'b0;
    gnt_dm = 1'b0;
    if (state_q == ST_IDLE) begin
      if (if_elig && (!dm_elig || fetch_turn) && !dm_next) begin
        gnt_if = 1'b1;
      end else if (dm_elig) begin
        gnt_dm = 1'b1;
      end else begin
        gnt_if = 1'b0;
        gnt_dm = 1'b0;
      end
    end else begin
      gnt_if = 1'b0;
      gnt_dm = 1'b0;
    end
  end

  // Consecutive data grants taken while fetch is waiting.
  always_comb begin
    run_d = run_q;
    if (!if_req || gnt_if) begin
      run_d = '0;
    end else if (gnt_dm && (run_q != RUN_MAX)) begin
      run_d = run_q + RW'(1);
    end else begin
      run_d = run_q;
    end
  end

  arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (to_load),
    .enable (to_en),
    .expire (to_expire)
  );

  // FSM next state, memory command and response capture.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_wr_d    = 1'b0;
    acc_wr_d    = acc_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = err_q;
    to_load     = 1'b0;
    to_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_if) begin
          state_d    = ST_SERV_IF;
          mem_req_d  = 1'b1;
          acc_wr_d   = 1'b0;
          mem_addr_d = if_addr;
          to_load    = 1'b1;
        end else if (gnt_dm) begin
          state_d     = ST_SERV_DM;
          mem_req_d   = 1'b1;
          mem_wr_d    = dm_wr;
          acc_wr_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          to_load     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV_IF: begin
        to_en = 1'b1;
        if (mem_done) begin
          state_d = ST_IDLE;
          if (!if_cancel) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b0;
          end
        end else if (to_expire) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (if_cancel) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SERV_IF;
        end
      end
      ST_SERV_DM: begin
        to_en = 1'b1;
        if (mem_done) begin
          state_d    = ST_IDLE;
          dm_valid_d = 1'b1;
          if (!acc_wr_q) begin
            dm_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else if (to_expire) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = ST_SERV_DM;
        end
      end
      ST_DRAIN: begin
        to_en = 1'b1;
        if (mem_done) begin
          state_d = ST_IDLE;
        end else if (to_expire) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      acc_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      acc_wr_q    <= acc_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign if_stall  = (if_req & ~if_valid_q) | (state_q == ST_ERR);
  assign dm_stall  = (dm_req & ~dm_valid_q) | (state_q == ST_ERR);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AW, 16, address width; DW, 16, data width; MAX_DM_RUN, 3, consecutive data grants allowed while fetch waits; TIMEOUT, 64, cycles allowed from mem_req to mem_done.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, reset; asynchronous, active-low.
- if_req, in, 1, fetch read request.
- if_addr, in, AW, fetch address.
- if_cancel, in, 1, fetch redirect; abandon the current fetch.
- if_rdata, out, DW, fetch read data.
- if_valid, out, 1, fetch access complete.
- if_stall, out, 1, fetch must hold.
- dm_req, in, 1, data-stage access request.
- dm_wr, in, 1, 1 = write, 0 = read.
- dm_addr, in, AW, data address.
- dm_wdata, in, DW, write data.
- dm_rdata, out, DW, data read data.
- dm_valid, out, 1, data access complete.
- dm_stall, out, 1, data stage must hold.
- mem_req, out, 1, one-cycle start pulse to the shared memory.
- mem_wr, out, 1, write qualifier.
- mem_addr, out, AW, memory address.
- mem_wdata, out, DW, memory write data.
- mem_rdata, in, DW, memory read data, valid with mem_done.
- mem_done, in, 1, access complete pulse.
- err, out, 1, sticky timeout error.

Function
REQ-003 The block shall share one single-ported, variable-latency memory between fetch (read-only) and the data stage (read/write), serving one access at a time.
REQ-004 FSM states shall be IDLE, SERV_IF, SERV_DM, DRAIN and ERR.
REQ-005 In IDLE with any eligible request, the block shall register the grant, address, wr and wdata, move to SERV_IF or SERV_DM, and drive mem_req=1 for exactly the first cycle of that state.
REQ-006 dm_req shall win over if_req, unless the data port has taken MAX_DM_RUN consecutive grants while if_req was pending; in that case fetch shall win.
REQ-007 The consecutive-grant counter shall clear on every fetch grant and on any cycle with if_req=0.
REQ-008 On mem_done in SERV_x, the block shall capture mem_rdata into x_rdata, pulse x_valid for one cycle on the next cycle, and return to IDLE.
REQ-009 Minimum latency shall be: request sampled at edge 0, mem_req in cycle 1, mem_done in cycle 1 or later, x_valid one cycle after mem_done.
REQ-010 x_stall shall equal x_req & ~x_valid, combinationally.
REQ-011 Requesters shall hold req, addr, wr and wdata stable until x_valid; in the cycle x_valid is high, that port's request shall not be eligible for a new grant.
REQ-012 On a write, dm_rdata shall be left unchanged and dm_valid shall still pulse.
REQ-013 if_cancel in SERV_IF, or in the same cycle as mem_done, shall move the block to DRAIN (or complete the access), and if_valid shall be suppressed for that access.
REQ-014 DRAIN shall wait for mem_done, then return to IDLE with no valid pulse.
REQ-015 if_cancel in IDLE or SERV_DM shall have no effect.
REQ-016 A watchdog shall count cycles in SERV_IF, SERV_DM and DRAIN; when it reaches TIMEOUT without mem_done, the block shall enter ERR, set err=1, and deassert mem_req.
REQ-017 In ERR, both stalls shall be held at 1 until reset.
REQ-018 mem_done received in IDLE or ERR shall be ignored.

Reset
REQ-019 With rst=0, the block shall asynchronously enter IDLE and clear to 0: all valid outputs, mem_req, mem_wr, err, the grant counter and the watchdog.
REQ-020 rdata and addr registers shall reset to 0.
REQ-021 Reset during an access shall abandon that access, and a late mem_done after reset release shall be ignored.

Structure
REQ-022 The state encoding and the widths of the default parameters shall live in a shared package, mem_arb_pkg.
REQ-023 The watchdog shall be one sub-module, arb_timeout (load, enable, expire), instantiated once.
REQ-024 The remaining logic (FSM, priority and capture) shall be flat in mem_arbiter.

Verification
REQ-025 Simultaneous if_req and dm_req (read, addr 0x0040), memory returning done after 2 cycles -> data served first, dm_valid with rdata; the fetch grant then follows.
REQ-026 dm_req held continuously, if_req held, MAX_DM_RUN=3 -> grant order DM, DM, DM, IF, DM.
REQ-027 if_cancel asserted in cycle 2 of a fetch, mem_done in cycle 4 -> no if_valid, IDLE in cycle 5, a new if_req is accepted.
REQ-028 Write of 0xBEEF to 0x0010, then a read of 0x0010 against a behavioural memory -> dm_rdata=0xBEEF, and mem_wr=1 only on the write's mem_req.
REQ-029 mem_done never returned -> err=1 exactly TIMEOUT cycles after mem_req, both stalls held at 1, recovery only via rst=0.
REQ-030 rst asserted in SERV_DM with mem_done arriving one cycle after release -> no dm_valid, state IDLE, all outputs 0.
